// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, word-addressed instruction RAM with host load port, IDLE/RUN/HALT sequencer.
// Optional IFU_PERF_CNT_EN adds fetch_count/redirect_count performance counter outputs.
module instr_fetch_unit #(
  parameter int          ADDR_W   = 8,
  parameter int          DEPTH    = 1 << ADDR_W,
  parameter logic [31:0] NOP_WORD = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [31:0]       branch_offset,
  input  logic              jump_taken,
  input  logic [25:0]       jump_target,
  output logic [31:0]       instruction,
  output logic              instr_valid,
  output logic [31:0]       pc,
  output logic              halted
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       redirect_count
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  localparam logic [ADDR_W:0] LEN_ONE = 1;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W:0]   prog_len_q, prog_len_d;

  logic [31:0]       mem [DEPTH];
  logic [31:0]       next_pc;
  logic [31:0]       rd_word;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   load_len;
  logic              in_prog;
  logic              mem_we;
  logic              do_start;

  always_comb begin
    mem_we   = (state_q != RUN) && load_en;
    do_start = (state_q != RUN) && !load_en && start && (prog_len_q != '0);
    load_len = {1'b0, load_addr} + LEN_ONE;

    if (jump_taken)        next_pc = {pc_q[31:26], jump_target};
    else if (branch_taken) next_pc = pc_q + 32'd1 + branch_offset;
    else                   next_pc = pc_q + 32'd1;

    // prog_len never exceeds DEPTH, so this also rejects targets past the RAM or negative wraps
    in_prog = next_pc < 32'(prog_len_q);
    rd_addr = do_start ? '0 : next_pc[ADDR_W-1:0];
    rd_word = mem[rd_addr];

    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    prog_len_d = prog_len_q;

    if (mem_we && (load_len > prog_len_q)) prog_len_d = load_len;

    case (state_q)
      IDLE, HALT: begin
        if (do_start) begin
          state_d = RUN;
          pc_d    = '0;
          instr_d = rd_word;
          valid_d = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          pc_d = next_pc;
          if (in_prog) begin
            instr_d = rd_word;
          end else begin
            state_d = HALT;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      instr_q    <= NOP_WORD;
      valid_q    <= 1'b0;
      prog_len_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      prog_len_q <= prog_len_d;
    end
  end

  // RAM contents survive reset; only the write is suppressed while rst is high
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[load_addr] <= load_data;
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign halted      = (state_q == HALT);

`ifdef IFU_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] redir_cnt_q, redir_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    redir_cnt_d = redir_cnt_q;
    if (do_start) begin
      fetch_cnt_d = '0;
      redir_cnt_d = '0;
    end else if ((state_q == RUN) && !stall && valid_q) begin
      if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if ((jump_taken || branch_taken) && (redir_cnt_q != 32'hFFFF_FFFF))
        redir_cnt_d = redir_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

  assign fetch_count    = fetch_cnt_q;
  assign redirect_count = redir_cnt_q;
`endif

endmodule
